// File: rtl/rcs_serial_sub.sv
// Bit-serial ripple-borrow subtractor: d = a - b, one bit per clock, LSB first.
// Operands and results move through independent valid/ready handshakes.
module rcs_serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, d_q;
  logic [IdxW-1:0]   idx_q;
  logic              br_q, bout_q;

  logic ai, bi, diff_bit, br_next;

  // Single time-shared full-subtractor cell
  always_comb begin
    ai       = a_q[idx_q];
    bi       = b_q[idx_q];
    diff_bit = ai ^ bi ^ br_q;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            d_q     <= '0;
            idx_q   <= '0;
            br_q    <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          d_q[idx_q] <= diff_bit;
          br_q       <= br_next;
          if (idx_q == LastIdx) begin
            bout_q  <= br_next;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags decode from state only, so no input reaches an output combinationally
  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign d_o         = d_q;
  assign bout_o      = bout_q;

endmodule
